// File: rtl/smc_mosfet_calc_if.sv
// Operand/result bundle for the six-device MOSFET calculator.
interface smc_mosfet_calc_if;
  logic [1:0] mode;
  logic [2:0] W_0, W_1, W_2, W_3, W_4, W_5;
  logic [2:0] V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5;
  logic [2:0] V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5;
  logic [9:0] out_n;
  logic       valid;

  modport master (
    output mode,
    output W_0, W_1, W_2, W_3, W_4, W_5,
    output V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
    output V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5,
    input  out_n,
    input  valid
  );

  modport slave (
    input  mode,
    input  W_0, W_1, W_2, W_3, W_4, W_5,
    input  V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
    input  V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5,
    output out_n,
    output valid
  );
endinterface

// File: rtl/smc_mosfet_calc.sv
// Six-device MOSFET Id/gm calculator: register inputs, pick three largest/smallest, weighted sum.
// Define SMC_ROUND_EN to make every divide-by-3 round to nearest instead of truncating.
module smc_mosfet_calc (
  input logic             clk,
  input logic             reset,
  smc_mosfet_calc_if.slave bus
);

  logic [1:0]      mode_q;
  logic [5:0][2:0] w_q, vgs_q, vds_q;
  logic            s1_ok;
  logic [9:0]      out_q;
  logic            valid_q;

  logic [5:0][8:0] dev_val, srt;
  logic [8:0]      w9, vgs9, vov9, vds9, num, tmp;
  logic [8:0]      n0, n1, n2;
  logic [9:0]      result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= '0;
      w_q     <= '0;
      vgs_q   <= '0;
      vds_q   <= '0;
      s1_ok   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= bus.mode;
      w_q     <= {bus.W_5, bus.W_4, bus.W_3, bus.W_2, bus.W_1, bus.W_0};
      vgs_q   <= {bus.V_GS_5, bus.V_GS_4, bus.V_GS_3, bus.V_GS_2, bus.V_GS_1, bus.V_GS_0};
      vds_q   <= {bus.V_DS_5, bus.V_DS_4, bus.V_DS_3, bus.V_DS_2, bus.V_DS_1, bus.V_DS_0};
      s1_ok   <= 1'b1;
      out_q   <= result;
      valid_q <= s1_ok;
    end
  end

  // vov is only used once V_GS > 1, so it is non-negative and can stay unsigned.
  always_comb begin
    dev_val = '0;
    w9      = '0;
    vgs9    = '0;
    vov9    = '0;
    vds9    = '0;
    num     = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      w9   = {6'd0, w_q[i]};
      vgs9 = {6'd0, vgs_q[i]};
      vds9 = {6'd0, vds_q[i]};
      vov9 = vgs9 - 9'd1;
      num  = '0;
      if (vgs9 > 9'd1) begin
        if (vov9 > vds9)
          num = mode_q[0] ? w9 * (((vov9 * vds9) << 1) - vds9 * vds9) : (w9 * vds9) << 1;
        else
          num = mode_q[0] ? w9 * vov9 * vov9 : (w9 * vov9) << 1;
`ifdef SMC_ROUND_EN
        num = num + 9'd1;
`else
        num = num;
`endif
      end
      dev_val[i] = num / 9'd3;
    end
  end

  // Descending bubble network; slots 0..2 are the largest three, 3..5 the smallest.
  always_comb begin
    srt = dev_val;
    tmp = '0;
    for (int unsigned p = 0; p < 5; p++) begin
      for (int unsigned j = 0; j < 5 - p; j++) begin
        if (srt[j] < srt[j+1]) begin
          tmp      = srt[j];
          srt[j]   = srt[j+1];
          srt[j+1] = tmp;
        end
      end
    end
  end

  always_comb begin
    n0 = mode_q[1] ? srt[0] : srt[3];
    n1 = mode_q[1] ? srt[1] : srt[4];
    n2 = mode_q[1] ? srt[2] : srt[5];
    if (mode_q[0])
      result = 10'd3 * {1'b0, n0} + 10'd4 * {1'b0, n1} + 10'd5 * {1'b0, n2};
    else
      result = {1'b0, n0} + {1'b0, n1} + {1'b0, n2};
  end

  assign bus.out_n = out_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_smc_mosfet_calc.sv
// Scoreboard bench for smc_mosfet_calc: directed plan vectors plus random traffic and mid-stream reset.
module tb_smc_mosfet_calc;

  typedef struct packed {
    logic [1:0]      mode;
    logic [5:0][2:0] w;
    logic [5:0][2:0] vgs;
    logic [5:0][2:0] vds;
  } vec_t;

  logic clk;
  logic reset;
  smc_mosfet_calc_if bus ();

  smc_mosfet_calc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int cur_exp  = 0;
  bit done     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dev(input int w, input int vgs, input int vds, input bit id);
    int vov, num;
    vov = vgs - 1;
    if (vgs <= 1) return 0;
    if (vov > vds) num = id ? w * (2 * vov * vds - vds * vds) : 2 * w * vds;
    else           num = id ? w * vov * vov : 2 * w * vov;
`ifdef SMC_ROUND_EN
    return (num + 1) / 3;
`else
    return num / 3;
`endif
  endfunction

  function automatic int model(input vec_t v);
    int q[$];
    int n0, n1, n2;
    for (int i = 0; i < 6; i++)
      q.push_back(dev(int'(v.w[i]), int'(v.vgs[i]), int'(v.vds[i]), v.mode[0]));
    q.rsort();
    if (v.mode[1]) begin n0 = q[0]; n1 = q[1]; n2 = q[2]; end
    else           begin n0 = q[3]; n1 = q[4]; n2 = q[5]; end
    return v.mode[0] ? 3 * n0 + 4 * n1 + 5 * n2 : n0 + n1 + n2;
  endfunction

  function automatic vec_t uni(input logic [1:0] m, input logic [2:0] w,
                               input logic [2:0] vgs, input logic [2:0] vds);
    vec_t v;
    v.mode = m;
    for (int i = 0; i < 6; i++) begin
      v.w[i] = w; v.vgs[i] = vgs; v.vds[i] = vds;
    end
    return v;
  endfunction

  function automatic vec_t ramp(input logic [1:0] m);
    vec_t v;
    v = uni(m, 3'd3, 3'd2, 3'd7);
    for (int i = 0; i < 6; i++) v.vgs[i] = 3'(i + 2);
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    v.mode = 2'($urandom_range(0, 3));
    for (int i = 0; i < 6; i++) begin
      v.w[i]   = 3'($urandom_range(0, 7));
      v.vgs[i] = 3'($urandom_range(0, 7));
      v.vds[i] = 3'($urandom_range(0, 7));
    end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.mode   = v.mode;
    bus.W_0    = v.w[0];   bus.W_1    = v.w[1];   bus.W_2    = v.w[2];
    bus.W_3    = v.w[3];   bus.W_4    = v.w[4];   bus.W_5    = v.w[5];
    bus.V_GS_0 = v.vgs[0]; bus.V_GS_1 = v.vgs[1]; bus.V_GS_2 = v.vgs[2];
    bus.V_GS_3 = v.vgs[3]; bus.V_GS_4 = v.vgs[4]; bus.V_GS_5 = v.vgs[5];
    bus.V_DS_0 = v.vds[0]; bus.V_DS_1 = v.vds[1]; bus.V_DS_2 = v.vds[2];
    bus.V_DS_3 = v.vds[3]; bus.V_DS_4 = v.vds[4]; bus.V_DS_5 = v.vds[5];
  endtask

  // Inputs change only here, 1 time unit after a rising edge.
  task automatic issue(input vec_t v, input int exp);
    drive(v);
    cur_exp = exp;
    exp_q.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!done && reset === 1'b1 && bus.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("out_n", int'(bus.out_n), exp_q.pop_front());
      end
    end
  end

  vec_t dir_v[$];
  int   dir_e[$];
  vec_t rv;

  initial begin
    vec_t rex;
    // Directed plan vectors with their hand-derived results.
    dir_v.push_back(uni(2'b11, 3'd3, 3'd3, 3'd3)); dir_e.push_back(48);
    dir_v.push_back(uni(2'b10, 3'd3, 3'd3, 3'd3)); dir_e.push_back(12);
    dir_v.push_back(ramp(2'b11));                   dir_e.push_back(288);
    dir_v.push_back(ramp(2'b01));                   dir_e.push_back(48);
    dir_v.push_back(ramp(2'b10));                   dir_e.push_back(30);
    dir_v.push_back(ramp(2'b00));                   dir_e.push_back(12);
    dir_v.push_back(uni(2'b11, 3'd3, 3'd7, 3'd1)); dir_e.push_back(132);
    dir_v.push_back(uni(2'b10, 3'd3, 3'd7, 3'd1)); dir_e.push_back(6);
    dir_v.push_back(uni(2'b11, 3'd7, 3'd7, 3'd7)); dir_e.push_back(1008);
    for (int m = 0; m < 4; m++) begin
      dir_v.push_back(uni(2'(m), 3'd7, 3'd1, 3'd5)); dir_e.push_back(0);
    end
    rex = uni(2'b11, 3'd2, 3'd1, 3'd7);
    rex.vgs[0] = 3'd3;
    dir_v.push_back(rex);
`ifdef SMC_ROUND_EN
    dir_e.push_back(9);
`else
    dir_e.push_back(6);
`endif

    reset = 1'b1;
    drive(uni(2'b00, 3'd0, 3'd0, 3'd0));
    #2 reset = 1'b0;
    tick();
    tick();
    check("reset_out_n", int'(bus.out_n), 0);
    check("reset_valid", int'(bus.valid), 0);

    drive(dir_v[0]);
    cur_exp = dir_e[0];
    #1 reset = 1'b1;
    exp_q.push_back(cur_exp);
    tick();
    check("valid_edge1", int'(bus.valid), 0);
    issue(dir_v[1], dir_e[1]);
    tick();
    check("valid_edge2", int'(bus.valid), 1);
    for (int k = 2; k < dir_v.size(); k++) begin
      issue(dir_v[k], dir_e[k]);
      tick();
    end
    for (int k = 0; k < 200; k++) begin
      rv = rnd();
      issue(rv, model(rv));
      tick();
    end

    // Mid-stream reset between edges: both stages discarded.
    #2 reset = 1'b0;
    #1;
    check("midrst_out_n", int'(bus.out_n), 0);
    check("midrst_valid", int'(bus.valid), 0);
    exp_q.delete();
    tick();
    rv = rnd();
    drive(rv);
    cur_exp = model(rv);
    #2 reset = 1'b1;
    exp_q.push_back(cur_exp);
    tick();
    check("rel_valid_edge1", int'(bus.valid), 0);
    rv = rnd();
    issue(rv, model(rv));
    tick();
    check("rel_valid_edge2", int'(bus.valid), 1);
    for (int k = 0; k < 100; k++) begin
      rv = rnd();
      issue(rv, model(rv));
      tick();
    end

    tick();
    #6;
    done = 1'b1;
    check("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smc_mosfet_calc.md
Name: smc_mosfet_calc

Overview:
Six-device MOSFET calculator with registered inputs and outputs. For each of six transistors it computes the drain current (Id) or the transconductance (gm) from W, V_GS and V_DS. It then selects the three largest or the three smallest results and outputs their weighted sum. It is a standalone datapath block with a fixed two-register pipeline and a valid flag.

Parameters:
None. All widths are fixed: operands are 3 bits, out_n is 10 bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low
mode  input  2  mode[0]: 1 = Id, 0 = gm; mode[1]: 1 = largest three, 0 = smallest three
W_0..W_5  input  3 each  channel width, unsigned 0..7
V_GS_0..V_GS_5  input  3 each  gate-source voltage, unsigned 0..7
V_DS_0..V_DS_5  input  3 each  drain-source voltage, unsigned 0..7
out_n  output  10  weighted result, unsigned
valid  output  1  high when out_n holds a computed result

Behaviour:
- Reset low (asynchronous): all input registers, out_n and valid clear to 0 immediately. Release is synchronous to the next clk edge.
- Stage 1: every rising edge samples mode and all 18 operands into registers. Sampling is unconditional; there is no input handshake.
- Stage 2: the next rising edge loads out_n with the result computed from the stage-1 registers.
  - Latency is 2 edges from input sample to out_n.
  - Throughput is one result per cycle.
- valid: 0 during reset and on the first edge after reset release. It goes to 1 on the second edge after release and stays 1 until the next reset.
- Per device i, let vov = V_GS_i - 1, computed signed.
  - Cutoff (V_GS_i <= 1): Id = 0, gm = 0.
  - Triode (vov > V_DS_i): Id = W*(2*vov*V_DS - V_DS^2)/3; gm = 2*W*V_DS/3.
  - Saturation (otherwise): Id = W*vov^2/3; gm = 2*W*vov/3.
  - Division by 3 truncates toward zero.
  - Id max = 84 and fits 7 bits; gm max = 28.
- Selection: the six values of the chosen quantity are sorted.
  - mode[1]=1 takes the three largest; mode[1]=0 takes the three smallest.
  - Call them n0 >= n1 >= n2, sorted descending within the chosen three. Ties are allowed; ordering among equal values does not affect the result.
- Output:
  - Id mode: out_n = 3*n0 + 4*n1 + 5*n2. Max is 1008, so no overflow in 10 bits.
  - gm mode: out_n = n0 + n1 + n2.
- A reset asserted mid-stream discards both pipeline stages. The first valid result after release reflects inputs sampled at the first post-release edge.

Optional Feature:
SMC_ROUND_EN
- Defined: every division by 3 rounds to nearest, i.e. (x+1)/3 truncated. Example: W=2, V_GS=3, V_DS=7 gives Id = 3.
- Undefined: truncating division. The same example gives Id = 2.
- Latency, valid timing and widths are identical in both builds.

Test Plan:
- All six devices W=3, V_GS=3, V_DS=3 (saturation, Id=4, gm=4) -> mode=11 gives out_n=48; mode=10 gives out_n=12; valid=1 two edges after sampling.
- W=3, V_DS=7, V_GS_i = 2..7 (Id = 1,4,9,16,25,36; gm = 2,4,6,8,10,12) -> mode=11: 288; mode=01: 48; mode=10: 30; mode=00: 12.
- All devices W=3, V_GS=7, V_DS=1 (triode, Id=11, gm=2) -> mode=11: 132; mode=10: 6.
- All devices W=7, V_GS=7, V_DS=7 -> mode=11: 1008. All devices V_GS=1 (cutoff) -> out_n=0 in every mode.
- Back-to-back cycles with different mode values -> each out_n matches its own inputs with a 2-edge lag and no bubbles.
- Assert reset low between edges mid-stream -> out_n=0 and valid=0 immediately; valid=0 on the first edge after release and 1 on the second.
